sequence_timer_controller: RTL and testbench
============================================

// Module: sequence_timer_controller
// PURPOSE
//  Sequences a serial-triggered delay timer. A Mealy 1101 detector watches `data`, then a
//  DELAY_BITS-wide delay is shifted in MSB-first and (delay+1)*UNIT_CYCLES cycles are counted.
//  `done` is held until `ack`, then detection re-arms. The block sits between the serial input
//  pin and downstream consumers of shift_ena/counting/done.
// PARAMETERS
//  DELAY_BITS   4     width of the serially loaded delay value (>=1)
//  UNIT_CYCLES  1000  clk cycles per delay unit (>=1); set to 4 in simulation
// PORTS
//  clk        in   1           single clock, all state on posedge
//  reset      in   1           synchronous, active-low; 0 at posedge -> idle
//  data       in   1           serial stream: pattern bits, then delay bits
//  ack        in   1           consumer acknowledge; sampled only in S_DONE
//  shift_ena  out  1           high during the DELAY_BITS delay-capture cycles
//  counting   out  1           high while the timer runs
//  count      out  DELAY_BITS  remaining whole units in S_COUNT; 0 in all other states
//  done       out  1           timer expired; held until ack
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=S_DETECT, detector history cleared, delay/unit counter=0;
//    all outputs 0 from that edge. Reset overrides everything, including mid-shift or mid-count.
//  - States: S_DETECT, S_SHIFT, S_COUNT, S_DONE. Outputs are decoded from registered state only.
//  - S_DETECT: detector sub-module runs with overlapping 1101 search (e.g. 1,1,1,0,1 matches on
//    5th bit). Mealy hit (detector at "110", data=1) in cycle N -> S_SHIFT at edge ending N.
//  - S_SHIFT: exactly DELAY_BITS cycles, shift_ena=1; each edge delay<={delay[DELAY_BITS-2:0],data}.
//    Bit counter 0..DELAY_BITS-1; on the last bit -> S_COUNT. First delay bit is the one present
//    in the cycle after the final pattern '1'.
//  - S_COUNT: counting=1, count=delay. unit_cnt runs 0..UNIT_CYCLES-1. At unit_cnt==UNIT_CYCLES-1:
//    if delay==0 -> S_DONE, else delay<=delay-1 and unit_cnt<=0. counting is high for exactly
//    (delay_loaded+1)*UNIT_CYCLES cycles. data and ack are ignored.
//  - S_DONE: done=1. ack=1 -> S_DETECT next edge and detector history cleared, so bits received
//    during S_COUNT/S_DONE never contribute to a match. ack=0 -> stay (no timeout).
//  - ack is ignored outside S_DONE. There is no re-trigger during S_SHIFT/S_COUNT/S_DONE.
//  - Widths: unit_cnt is $clog2(UNIT_CYCLES) bits, minimum 1; bit counter is $clog2(DELAY_BITS)
//    bits, minimum 1. No arithmetic wraps: delay decrements only while nonzero.
// STRUCTURE
//  - Package seq_timer_pkg: state encoding (S_DETECT..S_DONE, 2 bits), PATTERN=4'b1101,
//    detector state encodings.
//  - Sub-module pattern_detector_1101: Mealy detector with inputs clk, reset, clear, data and
//    output hit. clear is driven in S_DONE&&ack and in every non-S_DETECT cycle.
//  - Top level holds the sequencing FSM, delay shift register, unit counter and bit counter.
// TESTING (DELAY_BITS=4, UNIT_CYCLES=4)
//  1 data=1,1,0,1 then 0,1,0,1 -> shift_ena high 4 cycles starting the cycle after the last '1';
//    counting high 24 cycles; count=5,4,3,2,1,0 for 4 cycles each; then done=1.
//  2 pattern then delay 0,0,0,0 -> counting exactly 4 cycles with count=0; then done=1.
//  3 overlap: 1,1,1,0,1 -> shift starts after the 5th bit; 1,1,0,0,1,1,0,1 -> trigger only
//    after the 8th bit.
//  4 hold ack=0 for 10 cycles in S_DONE -> done stays 1; send 1,1,0,1 during S_DONE, then ack=1
//    -> S_DETECT with no trigger; a fresh 1101 is required to restart.
//  5 reset=0 for one edge mid-S_SHIFT and mid-S_COUNT -> all outputs 0 from that edge and
//    S_DETECT; a subsequent full sequence behaves as in test 1.
//  6 ack pulses during S_SHIFT and S_COUNT -> no effect; count sequence and counting length
//    unchanged.

Source files
------------

// File: rtl/seq_timer_pkg.sv
// Package for the sequence timer controller.
// Holds the sequencing FSM state encoding, the trigger pattern, the
// detector state encoding and a width helper shared by the RTL.
package seq_timer_pkg;

    // Sequencing FSM states (2-bit, legacy-compatible constants)
    localparam logic [1:0] S_DETECT = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_COUNT  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // Trigger pattern, first-received bit in the MSB
    localparam logic [3:0] PATTERN = 4'b1101;

    // Detector states: how much of the pattern prefix has been seen
    localparam logic [1:0] D_NONE = 2'd0;
    localparam logic [1:0] D_1    = 2'd1;
    localparam logic [1:0] D_11   = 2'd2;
    localparam logic [1:0] D_110  = 2'd3;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int width_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sequence_timer_controller_if.sv
// Bus between the serial source / downstream consumer and the controller.
//   data      : serial stream (pattern bits, then delay bits)
//   ack       : consumer acknowledge of done
//   shift_ena : delay bits are being captured
//   counting  : timer running
//   count     : remaining whole units while counting, else 0
//   done      : timer expired, held until ack
// master = stimulus/consumer side, slave = controller side.
interface sequence_timer_controller_if #(
    parameter int DELAY_BITS = 4
);
    logic                  data;
    logic                  ack;
    logic                  shift_ena;
    logic                  counting;
    logic [DELAY_BITS-1:0] count;
    logic                  done;

    modport master (
        output data, ack,
        input  shift_ena, counting, count, done
    );

    modport slave (
        input  data, ack,
        output shift_ena, counting, count, done
    );
endinterface

// File: rtl/sequence_timer_controller_detector.sv
// Mealy detector for the overlapping serial pattern 1101.
//   clk   : clock
//   reset : synchronous, active-low
//   clear : forces the history back to empty at the next edge and masks hit
//   data  : serial input bit
//   hit   : combinational, high in the cycle the final '1' is present
module pattern_detector_1101
    import seq_timer_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic data,
    output logic hit
);

    logic [1:0] det_q;
    logic [1:0] det_d;

    always_comb begin
        det_d = D_NONE;
        if (!clear) begin
            case (det_q)
                D_NONE: det_d = (data == PATTERN[3]) ? D_1 : D_NONE;
                D_1:    det_d = (data == PATTERN[2]) ? D_11 : D_NONE;
                // A further '1' after "11" still leaves a valid "11" suffix
                D_11:   det_d = (data == PATTERN[1]) ? D_110 : D_11;
                // After a hit the trailing '1' is itself a valid prefix
                D_110:  det_d = (data == PATTERN[0]) ? D_1 : D_NONE;
                default: det_d = D_NONE;
            endcase
        end
    end

    assign hit = !clear && (det_q == D_110) && (data == PATTERN[0]);

    always_ff @(posedge clk) begin
        if (!reset) begin
            det_q <= D_NONE;
        end else begin
            det_q <= det_d;
        end
    end

endmodule

// File: rtl/sequence_timer_controller.sv
// Serial-triggered delay timer.
// Waits for 1101 on data, shifts in a DELAY_BITS delay MSB-first, counts
// (delay+1)*UNIT_CYCLES cycles, then holds done until ack.
//   clk   : clock, all state on posedge
//   reset : synchronous, active-low
//   bus   : slave side of sequence_timer_controller_if
//           (data/ack in; shift_ena/counting/count/done out)
// Outputs are decoded from registered state only.
module sequence_timer_controller
    import seq_timer_pkg::*;
#(
    parameter int DELAY_BITS  = 4,
    parameter int UNIT_CYCLES = 1000
) (
    input  logic                          clk,
    input  logic                          reset,
    sequence_timer_controller_if.slave    bus
);

    localparam int UW = width_min1(UNIT_CYCLES);
    localparam int BW = width_min1(DELAY_BITS);
    localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DELAY_BITS - 1);

    logic [1:0]            state_q, state_d;
    logic [DELAY_BITS-1:0] delay_q, delay_d;
    logic [UW-1:0]         unit_cnt_q, unit_cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DELAY_BITS-1:0] delay_shifted;
    logic                  hit;
    logic                  det_clear;

    // A one-bit delay has no older bits to keep
    generate
        if (DELAY_BITS == 1) begin : g_shift_one
            assign delay_shifted = bus.data;
        end else begin : g_shift_many
            assign delay_shifted = {delay_q[DELAY_BITS-2:0], bus.data};
        end
    endgenerate

    // Detector history only lives while searching; any other state wipes it,
    // so bits seen while busy or waiting for ack can never form a match.
    assign det_clear = (state_q != S_DETECT);

    pattern_detector_1101 u_detector (
        .clk   (clk),
        .reset (reset),
        .clear (det_clear),
        .data  (bus.data),
        .hit   (hit)
    );

    always_comb begin
        state_d    = state_q;
        delay_d    = delay_q;
        unit_cnt_d = unit_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        case (state_q)
            S_DETECT: begin
                if (hit) begin
                    state_d    = S_SHIFT;
                    bit_cnt_d  = '0;
                    unit_cnt_d = '0;
                end
            end
            S_SHIFT: begin
                delay_d = delay_shifted;
                if (bit_cnt_q == BIT_LAST) begin
                    state_d    = S_COUNT;
                    unit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            S_COUNT: begin
                if (unit_cnt_q == UNIT_LAST) begin
                    unit_cnt_d = '0;
                    // The zero unit is counted too, hence delay+1 units total
                    if (delay_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        delay_d = delay_q - 1'b1;
                    end
                end else begin
                    unit_cnt_d = unit_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (bus.ack) begin
                    state_d = S_DETECT;
                end
            end
            default: state_d = S_DETECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_DETECT;
            delay_q    <= '0;
            unit_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            delay_q    <= delay_d;
            unit_cnt_q <= unit_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign bus.shift_ena = (state_q == S_SHIFT);
    assign bus.counting  = (state_q == S_COUNT);
    assign bus.count     = (state_q == S_COUNT) ? delay_q : '0;
    assign bus.done      = (state_q == S_DONE);

endmodule

// File: tb/tb_sequence_timer_controller.sv
// Scoreboard bench: every driven cycle pushes the outputs that cycle must
// show; a negedge checker pops and compares.
module tb_sequence_timer_controller;

    localparam int DB = 4;
    localparam int UC = 4;

    typedef struct packed {
        logic       sh;
        logic       cn;
        logic [3:0] cv;
        logic       dn;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    exp_t exp_q[$];
    exp_t chk_e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sequence_timer_controller_if #(.DELAY_BITS(DB)) dut_if ();

    sequence_timer_controller #(
        .DELAY_BITS  (DB),
        .UNIT_CYCLES (UC)
    ) dut (
        .clk   (clk),
        .reset (reset_n),
        .bus   (dut_if.slave)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            chk_e = exp_q.pop_front();
            check_val("shift_ena", {31'd0, dut_if.shift_ena}, {31'd0, chk_e.sh});
            check_val("counting",  {31'd0, dut_if.counting},  {31'd0, chk_e.cn});
            check_val("count",     {28'd0, dut_if.count},     {28'd0, chk_e.cv});
            check_val("done",      {31'd0, dut_if.done},      {31'd0, chk_e.dn});
        end
    end

    // One clock cycle: drive inputs, record what this cycle must show
    task automatic step(input logic d, input logic a, input logic r,
                        input logic sh, input logic cn, input logic [3:0] cv, input logic dn);
        exp_t e;
        dut_if.data = d;
        dut_if.ack  = a;
        reset_n     = r;
        e.sh = sh; e.cn = cn; e.cv = cv; e.dn = dn;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Bits sent while searching: outputs stay idle, including the hit cycle
    task automatic det_bits(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            step(bits[i], 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        end
    endtask

    task automatic shift_bits(input logic [3:0] v, input int n, input logic ack_pulse);
        for (int i = 0; i < n; i++) begin
            step(v[3-i], ack_pulse && (i % 2 == 0), 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        end
    endtask

    // v, v-1, .. 0, each shown for UC cycles; data is random and must not matter
    task automatic count_phase(input int v, input logic ack_pulse);
        for (int k = v; k >= 0; k--) begin
            for (int u = 0; u < UC; u++) begin
                step(1'($urandom_range(0, 1)), ack_pulse && (u == 1), 1'b1,
                     1'b0, 1'b1, 4'(k), 1'b0);
            end
        end
    endtask

    task automatic done_phase(input int hold);
        for (int i = 0; i < hold; i++) begin
            step(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        end
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic run_seq(input logic [3:0] v, input logic ack_pulse);
        det_bits(16'b1101, 4);
        shift_bits(v, 4, ack_pulse);
        count_phase(int'(v), ack_pulse);
        done_phase(2);
        $display("sequence delay=%0d ack_pulses=%0d complete, checks=%0d", v, ack_pulse, checks);
    endtask

    initial begin
        reset_n     = 1'b0;
        dut_if.data = 1'b0;
        dut_if.ack  = 1'b0;
        @(posedge clk);
        #1;

        // reset state
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        $display("reset state sampled");

        // 1: basic delay 5
        run_seq(4'd5, 1'b0);

        // 2: delay 0 -> one unit of counting
        run_seq(4'd0, 1'b0);

        // 3: overlapping detection
        det_bits(16'b11101, 5);
        shift_bits(4'd1, 4, 1'b0);
        count_phase(1, 1'b0);
        done_phase(1);
        $display("overlap 11101 triggered after 5th bit");
        det_bits(16'b11001101, 8);
        shift_bits(4'd2, 4, 1'b0);
        count_phase(2, 1'b0);
        done_phase(1);
        $display("11001101 triggered after 8th bit only");

        // 4: long done hold with a pattern sent meanwhile, then no stale trigger
        det_bits(16'b1101, 4);
        shift_bits(4'd0, 4, 1'b0);
        count_phase(0, 1'b0);
        begin
            logic [9:0] hold_bits;
            hold_bits = 10'b0000001101;
            for (int i = 9; i >= 0; i--) begin
                step(hold_bits[i], 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
            end
        end
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        det_bits(16'b101, 3);
        det_bits(16'b0000, 4);
        $display("done held 10 cycles, stale pattern ignored after ack");
        run_seq(4'd1, 1'b0);

        // 5: reset mid-shift and mid-count
        det_bits(16'b1101, 4);
        shift_bits(4'b1010, 2, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        $display("reset during shift returned to idle");
        det_bits(16'b1101, 4);
        shift_bits(4'd3, 4, 1'b0);
        for (int u = 0; u < UC; u++) begin
            step(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        $display("reset during count returned to idle");
        run_seq(4'd5, 1'b0);

        // 6: ack pulses while shifting and counting are ignored
        run_seq(4'd5, 1'b1);

        @(negedge clk);
        #1;
        check_val("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
